// File: rtl/udp_cmd_decode.sv
// udp_cmd_decode
// Decodes fixed 7-byte motor-control command packets from the UDP payload
// stream and commits validated values to the PID setpoint/gain/enable
// registers. Malformed packets are dropped and counted.
//
// Packet: MAGIC, CMD, V3, V2, V1, V0 (big-endian value), CSUM (XOR of bytes 0..5)
//
// Ports:
//   clk50             - system clock (50 MHz)
//   rst               - synchronous active-high reset
//   udp_dst_port      - destination port of current datagram
//   udp_payload       - payload byte
//   udp_payload_valid - byte strobe
//   udp_payload_last  - marks the final payload byte
//   setpoint          - signed motor setpoint (cmd 0x01)
//   kp, ki, kd        - unsigned gains (cmd 0x02..0x04)
//   pid_enable        - PID run enable (cmd 0x05)
//   cfg_update        - one-cycle pulse on commit
//   cmd_err           - one-cycle pulse on a counted error
//   err_code          - cause of last error (0 magic, 1 cmd, 2 length, 3 checksum)
//   err_cnt           - saturating error count
module udp_cmd_decode #(
    parameter logic [15:0] LISTEN_PORT = 16'd5005,
    parameter logic [7:0]  MAGIC       = 8'hA5
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic [15:0] udp_dst_port,
    input  logic [7:0]  udp_payload,
    input  logic        udp_payload_valid,
    input  logic        udp_payload_last,
    output logic [31:0] setpoint,
    output logic [15:0] kp,
    output logic [15:0] ki,
    output logic [15:0] kd,
    output logic        pid_enable,
    output logic        cfg_update,
    output logic        cmd_err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned VAL_W  = 32;
    localparam int unsigned GAIN_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;

    localparam logic [1:0] ERR_MAGIC = 2'd0;
    localparam logic [1:0] ERR_CMD   = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_CSUM  = 2'd3;

    localparam logic [BYTE_W-1:0] CMD_SETPOINT = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_KP       = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_KI       = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_KD       = 8'h04;
    localparam logic [BYTE_W-1:0] CMD_ENABLE   = 8'h05;

    localparam logic [IDX_W-1:0]  IDX_LAST     = 2'd3;
    localparam logic [CNT_W-1:0]  CNT_MAX      = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BYTE_W-1:0]   xor_q, xor_d;
    logic [BYTE_W-1:0]   cmd_q, cmd_d;
    logic [VAL_W-1:0]    val_q, val_d;

    logic                commit_c;
    logic                err_c;
    logic [1:0]          err_sel_c;
    logic                cmd_ok_c;
    logic                last_c;

    assign cmd_ok_c = (udp_payload >= CMD_SETPOINT) && (udp_payload <= CMD_ENABLE);
    assign last_c   = udp_payload_last;

    // Next-state, datapath and commit/error decode; only valid bytes advance anything
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        cmd_d     = cmd_q;
        val_d     = val_q;
        commit_c  = 1'b0;
        err_c     = 1'b0;
        err_sel_c = ERR_MAGIC;

        if (udp_payload_valid) begin
            case (state_q)
                S_IDLE: begin
                    // XOR restarts from byte 0 of every packet
                    xor_d = udp_payload;
                    idx_d = '0;
                    if (udp_dst_port != LISTEN_PORT) begin
                        // Not ours: swallow silently until the datagram ends
                        state_d = last_c ? S_IDLE : S_DRAIN;
                    end else if (udp_payload != MAGIC) begin
                        err_c     = 1'b1;
                        err_sel_c = ERR_MAGIC;
                        state_d   = last_c ? S_IDLE : S_DRAIN;
                    end else if (last_c) begin
                        err_c     = 1'b1;
                        err_sel_c = ERR_LEN;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_HDR;
                    end
                end

                S_HDR: begin
                    if (!cmd_ok_c) begin
                        err_c     = 1'b1;
                        err_sel_c = ERR_CMD;
                        state_d   = last_c ? S_IDLE : S_DRAIN;
                    end else if (last_c) begin
                        err_c     = 1'b1;
                        err_sel_c = ERR_LEN;
                        state_d   = S_IDLE;
                    end else begin
                        cmd_d   = udp_payload;
                        xor_d   = xor_q ^ udp_payload;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end

                S_DATA: begin
                    val_d = {val_q[VAL_W-BYTE_W-1:0], udp_payload};
                    xor_d = xor_q ^ udp_payload;
                    if (last_c) begin
                        err_c     = 1'b1;
                        err_sel_c = ERR_LEN;
                        state_d   = S_IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = S_CSUM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end

                S_CSUM: begin
                    if (!last_c) begin
                        // Too long: length error wins over a matching checksum
                        err_c     = 1'b1;
                        err_sel_c = ERR_LEN;
                        state_d   = S_DRAIN;
                    end else if (udp_payload == xor_q) begin
                        commit_c = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        err_c     = 1'b1;
                        err_sel_c = ERR_CSUM;
                        state_d   = S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (last_c) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Decoder state register
    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            xor_q   <= '0;
            cmd_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
            cmd_q   <= cmd_d;
            val_q   <= val_d;
        end
    end

    // Configuration registers and error reporting
    always_ff @(posedge clk50) begin
        if (rst) begin
            setpoint   <= '0;
            kp         <= '0;
            ki         <= '0;
            kd         <= '0;
            pid_enable <= 1'b0;
            cfg_update <= 1'b0;
            cmd_err    <= 1'b0;
            err_code   <= '0;
            err_cnt    <= '0;
        end else begin
            cfg_update <= commit_c;
            cmd_err    <= err_c;

            if (err_c) begin
                err_code <= err_sel_c;
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end

            // val_q holds all four value bytes by the time the CSUM byte arrives
            if (commit_c) begin
                case (cmd_q)
                    CMD_SETPOINT: setpoint   <= val_q;
                    CMD_KP:       kp         <= val_q[GAIN_W-1:0];
                    CMD_KI:       ki         <= val_q[GAIN_W-1:0];
                    CMD_KD:       kd         <= val_q[GAIN_W-1:0];
                    CMD_ENABLE:   pid_enable <= val_q[0];
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_cmd_decode.sv
`timescale 1ns/1ps
module tb_udp_cmd_decode;

    logic        clk50 = 1'b0;
    logic        rst;
    logic [15:0] udp_dst_port;
    logic [7:0]  udp_payload;
    logic        udp_payload_valid;
    logic        udp_payload_last;
    logic [31:0] setpoint;
    logic [15:0] kp, ki, kd;
    logic        pid_enable, cfg_update, cmd_err;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk50 = ~clk50;

    udp_cmd_decode dut (
        .clk50             (clk50),
        .rst               (rst),
        .udp_dst_port      (udp_dst_port),
        .udp_payload       (udp_payload),
        .udp_payload_valid (udp_payload_valid),
        .udp_payload_last  (udp_payload_last),
        .setpoint          (setpoint),
        .kp                (kp),
        .ki                (ki),
        .kd                (kd),
        .pid_enable        (pid_enable),
        .cfg_update        (cfg_update),
        .cmd_err           (cmd_err),
        .err_code          (err_code),
        .err_cnt           (err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    logic [31:0] m_setpoint;
    logic [15:0] m_kp, m_ki, m_kd;
    logic        m_en, m_cfg, m_err;
    logic [1:0]  m_code;
    logic [7:0]  m_cnt;
    logic [7:0]  pkt [$];
    bit          dropped;

    always @(posedge clk50) begin : model
        int n;
        int e;
        bit fin;
        logic [7:0]  x;
        logic [31:0] v;
        m_cfg = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_setpoint = '0; m_kp = '0; m_ki = '0; m_kd = '0; m_en = 1'b0;
            m_code = '0; m_cnt = '0;
            pkt.delete();
            dropped = 1'b0;
        end else if (udp_payload_valid) begin
            if (dropped) begin
                if (udp_payload_last) dropped = 1'b0;
            end else begin
                pkt.push_back(udp_payload);
                n   = pkt.size();
                e   = -1;
                fin = 1'b0;
                if (n == 1 && udp_dst_port != 16'd5005) fin = 1'b1;
                else if (n == 1 && pkt[0] != 8'hA5) e = 0;
                else if (n == 2 && (pkt[1] < 8'h01 || pkt[1] > 8'h05)) e = 1;
                else if (n < 7 && udp_payload_last) e = 2;
                else if (n == 7 && !udp_payload_last) e = 2;
                else if (n == 7) begin
                    x = 8'h00;
                    for (int i = 0; i < 6; i++) x ^= pkt[i];
                    if (x == pkt[6]) begin
                        v = {pkt[2], pkt[3], pkt[4], pkt[5]};
                        m_cfg = 1'b1;
                        case (pkt[1])
                            8'h01: m_setpoint = v;
                            8'h02: m_kp = v[15:0];
                            8'h03: m_ki = v[15:0];
                            8'h04: m_kd = v[15:0];
                            default: m_en = v[0];
                        endcase
                    end else begin
                        e = 3;
                    end
                end
                if (e >= 0) begin
                    m_err  = 1'b1;
                    m_code = 2'(e);
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                end
                if (e >= 0 || fin || udp_payload_last || n == 7) begin
                    pkt.delete();
                    dropped = !udp_payload_last;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk50) begin
        chk("setpoint",   setpoint,          m_setpoint);
        chk("kp",         32'(kp),           32'(m_kp));
        chk("ki",         32'(ki),           32'(m_ki));
        chk("kd",         32'(kd),           32'(m_kd));
        chk("pid_enable", 32'(pid_enable),   32'(m_en));
        chk("cfg_update", 32'(cfg_update),   32'(m_cfg));
        chk("cmd_err",    32'(cmd_err),      32'(m_err));
        chk("err_code",   32'(err_code),     32'(m_code));
        chk("err_cnt",    32'(err_cnt),      32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    // Bytes taken MSB-first from the low n bytes of data; last on final byte if with_last
    task automatic send_pkt(input logic [71:0] data, input int n, input int gap, input bit with_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk50);
            udp_payload_valid = 1'b1;
            udp_payload       = data[8*(n-1-i) +: 8];
            udp_payload_last  = with_last && (i == n - 1);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk50);
                udp_payload_valid = 1'b0;
                udp_payload_last  = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk50);
            udp_payload_valid = 1'b0;
            udp_payload_last  = 1'b0;
        end
    endtask

    initial begin
        rst               = 1'b1;
        udp_dst_port      = 16'd5005;
        udp_payload       = 8'h00;
        udp_payload_valid = 1'b0;
        udp_payload_last  = 1'b0;
        repeat (3) @(negedge clk50);
        chk("rst_setpoint", setpoint, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_cfg_update", 32'(cfg_update), 32'd0);
        rst = 1'b0;

        // 1: setpoint = 1000, back-to-back
        send_pkt(72'h00_00_A5_01_00_00_03_E8_4F, 7, 0, 1'b1);
        idle(1);
        chk("t1_setpoint", setpoint, 32'd1000);
        chk("t1_cfg_pulse", 32'(cfg_update), 32'd1);
        idle(1);
        chk("t1_cfg_once", 32'(cfg_update), 32'd0);

        // 2: kp = 0x0100 with gaps
        send_pkt(72'h00_00_A5_02_00_00_01_00_A6, 7, 3, 1'b1);
        idle(1);
        chk("t2_kp", 32'(kp), 32'h0100);
        chk("t2_setpoint", setpoint, 32'd1000);
        chk("t2_ki", 32'(ki), 32'd0);

        // 3: checksum error
        send_pkt(72'h00_00_A5_01_00_00_03_E8_4E, 7, 0, 1'b1);
        idle(1);
        chk("t3_cmd_err", 32'(cmd_err), 32'd1);
        chk("t3_err_code", 32'(err_code), 32'd3);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        chk("t3_setpoint", setpoint, 32'd1000);

        // 4a: short packet
        send_pkt(72'h00_00_00_00_A5_01_00_00_03, 5, 0, 1'b1);
        idle(1);
        chk("t4a_err_code", 32'(err_code), 32'd2);
        chk("t4a_err_cnt", 32'(err_cnt), 32'd2);

        // 4b: long packet drained, then a good ki packet
        send_pkt(72'hA5_03_00_00_12_34_80_11_22, 9, 0, 1'b1);
        idle(1);
        chk("t4b_err_code", 32'(err_code), 32'd2);
        chk("t4b_err_cnt", 32'(err_cnt), 32'd3);
        chk("t4b_ki_untouched", 32'(ki), 32'd0);
        send_pkt(72'h00_00_A5_03_00_00_12_34_80, 7, 0, 1'b1);
        idle(1);
        chk("t4b_ki", 32'(ki), 32'h1234);

        // Back-to-back kd, enable, negative setpoint
        send_pkt(72'h00_00_A5_04_00_00_AB_CD_C7, 7, 0, 1'b1);
        send_pkt(72'h00_00_A5_05_00_00_00_01_A1, 7, 0, 1'b1);
        send_pkt(72'h00_00_A5_01_FF_FF_FF_00_5B, 7, 0, 1'b1);
        idle(1);
        chk("b2b_kd", 32'(kd), 32'hABCD);
        chk("b2b_enable", 32'(pid_enable), 32'd1);
        chk("b2b_setpoint", setpoint, 32'hFFFF_FF00);

        // 5: wrong port ignored silently
        udp_dst_port = 16'd5006;
        send_pkt(72'h00_00_A5_01_00_00_03_E8_4F, 7, 0, 1'b1);
        idle(1);
        udp_dst_port = 16'd5005;
        chk("t5_port_setpoint", setpoint, 32'hFFFF_FF00);
        chk("t5_port_err_cnt", 32'(err_cnt), 32'd3);

        send_pkt(72'h00_00_5A_01_00_00_03_E8_4F, 7, 0, 1'b1);
        idle(1);
        chk("t5_magic_code", 32'(err_code), 32'd0);
        chk("t5_magic_cnt", 32'(err_cnt), 32'd4);

        send_pkt(72'h00_00_A5_07_00_00_03_E8_4F, 7, 0, 1'b1);
        idle(1);
        chk("t5_cmd_code", 32'(err_code), 32'd1);
        chk("t5_cmd_cnt", 32'(err_cnt), 32'd5);

        // 6: saturation with single-byte bad-magic packets
        for (int k = 0; k < 300; k++) send_pkt(72'h5A, 1, 0, 1'b1);
        idle(1);
        chk("t6_sat_cnt", 32'(err_cnt), 32'd255);
        chk("t6_sat_code", 32'(err_code), 32'd0);

        // Reset during byte 3 of a valid packet
        send_pkt(72'h00_00_00_00_00_00_A5_01_00, 3, 0, 1'b0);
        @(negedge clk50);
        rst               = 1'b1;
        udp_payload_valid = 1'b1;
        udp_payload       = 8'h00;
        udp_payload_last  = 1'b0;
        @(negedge clk50);
        rst               = 1'b0;
        udp_payload_valid = 1'b0;
        chk("rst_mid_setpoint", setpoint, 32'd0);
        chk("rst_mid_kp", 32'(kp), 32'd0);
        chk("rst_mid_enable", 32'(pid_enable), 32'd0);
        chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
        send_pkt(72'h00_00_A5_01_00_00_03_E8_4F, 7, 0, 1'b1);
        idle(1);
        chk("post_rst_setpoint", setpoint, 32'd1000);
        chk("post_rst_cfg", 32'(cfg_update), 32'd1);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_cmd_decode.md
# udp_cmd_decode

Consumes the UDP payload byte stream produced by the Ethernet receive parser and decodes fixed 7-byte motor-control command packets.
- Validated commands update the PID setpoint, gain and enable registers that feed the motor PID controller.
- Malformed packets are dropped and counted; the registers are left untouched.
- The block sits between the UDP receive path and the PID core, in the `clk50` domain.

## Interface

Parameters:
- `LISTEN_PORT`, 16'd5005: UDP destination port that is accepted.
- `MAGIC`, 8'hA5: required first payload byte.

Ports:
- `clk50` in 1: system clock, 50 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `udp_dst_port` in 16: destination port of the current datagram; stable while payload is streamed.
- `udp_payload` in 8: payload byte.
- `udp_payload_valid` in 1: byte strobe; one byte per asserted cycle, gaps allowed.
- `udp_payload_last` in 1: qualifies the final payload byte; meaningful only when valid.
- `setpoint` out 32: signed motor setpoint.
- `kp`, `ki`, `kd` out 16 each: unsigned gains.
- `pid_enable` out 1: PID run enable.
- `cfg_update` out 1: one-cycle pulse when any register is committed.
- `cmd_err` out 1: one-cycle pulse on a counted error.
- `err_code` out 2: cause of the last error. 0 = magic, 1 = cmd, 2 = length, 3 = checksum.
- `err_cnt` out 8: saturating error count.

## Operation

Packet format, in byte order:
- `MAGIC`
- CMD
- V3, V2, V1, V0: 32-bit value, big-endian
- CSUM

CSUM equals the XOR of bytes 0..5. Exactly 7 bytes; `udp_payload_last` must arrive with byte 6.

CMD encoding:
- 0x01 writes `setpoint` from the full 32-bit value.
- 0x02, 0x03 and 0x04 write `kp`, `ki` and `kd` from value[15:0].
- 0x05 writes `pid_enable` from value[0].

States:
- **IDLE**: the first valid byte is byte 0.
  - If `udp_dst_port` != `LISTEN_PORT`, go to DRAIN silently (no error, no count).
  - Else if byte != `MAGIC`, raise error 0 and go to DRAIN.
  - Else go to HDR.
- **HDR**: the byte is CMD. If CMD is not in 0x01..0x05, raise error 1 and go to DRAIN. Else latch CMD and go to DATA.
- **DATA**: shift in 4 bytes, MSB first, counted by a 2-bit index. Go to CSUM after V0.
- **CSUM**: compare the byte against the running XOR.
  - If last = 1 and it matches, commit and go to IDLE.
  - If last = 1 and it mismatches, raise error 3 and go to IDLE.
  - If last = 0, raise error 2 and go to DRAIN, even if the checksum matches.
- **DRAIN**: discard bytes until a valid byte with last = 1 is seen, then go to IDLE.

Boundary rules:
- `udp_payload_last` on any byte before byte 6, in IDLE, HDR or DATA, with no other error: raise error 2 and go to IDLE.
- If magic or cmd fails on a byte that also carries last: raise that error (0 or 1), not error 2, and go to IDLE directly (skip DRAIN).
- Running XOR resets in IDLE and accumulates bytes 0..5.

Error handling:
- An error sets `err_code`, pulses `cmd_err`, and increments `err_cnt`.
- `err_cnt` saturates at 255.
- Registers are never written on error.

Reset behaviour:
- Reset values: all registers 0, `pid_enable` 0, pulses 0, `err_code` 0, `err_cnt` 0, state IDLE.
- Reset mid-packet drops the partial packet. The next valid byte is treated as byte 0.

## Timing

- **Commit:** on the `clk50` edge that samples a valid, matching CSUM byte with last = 1, the target register and `cfg_update` update together. The new value is visible the following cycle.
- **Latency:** one cycle from CSUM byte to output.
- **Errors:** `cmd_err`, `err_code` and `err_cnt` update on the edge that samples the offending byte.
- **Pulses:** `cfg_update` and `cmd_err` are high for exactly one cycle and are never high together.
- **Idle cycles:** cycles with `udp_payload_valid` = 0 change no state, index or XOR.
- **Throughput:** the block accepts a byte every cycle. Back-to-back packets need no idle cycle between the last byte of one and byte 0 of the next.
- **Reset:** `rst` has priority over everything, including a commit on the same edge.

## Test plan

1. Send A5 01 00 00 03 E8 4F, back-to-back, port 5005. Expect `setpoint` = 1000 one cycle after the last byte and one `cfg_update` pulse.
2. Send A5 02 00 00 01 00 A6 with 3-cycle gaps between bytes. Expect `kp` = 0x0100 and the other registers unchanged.
3. Send scenario 1 with CSUM = 0x4E. Expect `setpoint` unchanged, `err_code` = 3, `err_cnt` = 1 and one `cmd_err` pulse.
4. Length errors:
   - A 5-byte packet with last on byte 4 gives `err_code` = 2 and a return to IDLE.
   - A 9-byte packet gives `err_code` = 2 and is drained. A following valid packet commits correctly.
5. Port 5006 with a valid packet: no commit and no error. Magic 0x5A: `err_code` = 0. CMD 0x07: `err_code` = 1.
6. 300 bad-magic packets give `err_cnt` = 255, saturated. Assert `rst` during byte 3 of a valid packet: all outputs return to 0, and the next full valid packet commits.
